tff_updown_counter: RTL and testbench
=====================================

# tff_updown_counter

Synchronous modulo-N up/down counter built from a column of T flip-flop cells. Toggle-enable logic decides which cells toggle each cycle. The block sits directly downstream of the single-bit toggle cell and turns it into a loadable multi-bit count with terminal-count and wrap outputs. It is used as the standard event/divider counter in the lab designs.

## Interface
- `WIDTH`, default 4: counter width in bits.
- `MODULO`, default 10: count range is 0..MODULO-1. Legal range is 2 ≤ MODULO ≤ 2**WIDTH; an illegal value stops elaboration.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `en` input 1: count enable for one step per cycle.
- `up` input 1: direction; 1 = increment, 0 = decrement.
- `load` input 1: parallel load request.
- `din` input WIDTH: load value.
- `q` output WIDTH: current count, registered.
- `tc` output 1: terminal count, combinational.
- `wrap` output 1: registered one-cycle pulse.

## Operation
- **State:** WIDTH T cells. Each cell updates as `q[i] <= q[i] ^ t[i]`. All behaviour is expressed as the toggle vector `t`, chosen by the priority list below.
- **Priority:** `rst` > `load` > `en`. If neither `load` nor `en` is asserted, `t = 0` and the count holds.
- **rst = 1:** `q <= 0` and `wrap <= 0`, regardless of the other inputs.
- **load = 1:**
  - `t = q ^ din'`, so `q <= din'`.
  - `din' = din` when `din < MODULO`; otherwise `din' = MODULO-1` (saturating clamp).
  - Load never asserts `wrap`.
- **Count up** (`en = 1`, `up = 1`):
  - If `q == MODULO-1`: `t = q`, so `q <= 0` and `wrap <= 1`.
  - Else: `t[0] = 1` and `t[i] = &q[i-1:0]`.
- **Count down** (`en = 1`, `up = 0`):
  - If `q == 0`: `t = MODULO-1`, so `q <= MODULO-1` and `wrap <= 1`.
  - Else: `t[0] = 1` and `t[i] = ~|q[i-1:0]`.
- **tc:** `tc = en & ~load & ((up & q == MODULO-1) | (~up & q == 0))`. It predicts that a wrap will occur on the next edge.
- **wrap:** equals the registered value of `tc`. It is high for exactly one cycle after each wrapping edge and 0 otherwise.
- **Direction change:** allowed on any cycle and takes effect at the next edge. No extra state is held.
- **Power-of-two MODULO:** when `MODULO == 2**WIDTH`, the wrap branches produce the same `t` as natural binary counting; the behaviour is identical.

## Timing
- Count, load and reset each take effect with 1-cycle latency: input sampled at edge k, `q` updated after edge k.
- `tc` is valid in the same cycle as `q` and `en`/`up`/`load`, with no latency.
- `wrap` is high during the cycle immediately after the wrapping edge.
- **Reset mid-count:** the cycle after `rst` has `q = 0` and `wrap = 0`. If `en` is held, counting resumes on the first edge with `rst = 0`.
- **Simultaneous load and en:** load wins, and no count or wrap occurs in that cycle.
- **Reset values:** `q = 0`, `wrap = 0`. `tc` follows its equation, e.g. `tc = 1` after reset when `en = 1` and `up = 0`.

## Structure
- Package `tff_pkg`:
  - Direction constants `DIR_DOWN = 1'b0`, `DIR_UP = 1'b1`.
  - Function `tff_toggle_for(cur, nxt)` returning `cur ^ nxt`, shared with later toggle-based blocks.
- Sub-module `tff_cell`, ports `clk`, `rst`, `t`, `q`:
  - 1-bit T flip-flop with synchronous active-high reset to 0.
  - Instantiated WIDTH times with a generate loop.
- The top level holds the clamp logic, the toggle-vector mux, the `tc` comparator and the `wrap` register. The `wrap` register is an ordinary flop, not a T cell.

## Test plan
All scenarios use WIDTH=4, MODULO=10.
- **Reset:** `rst = 1` for 2 cycles with `en = 1`, `up = 1` → `q = 0`, `wrap = 0`. After release, 12 enabled cycles give `q` = 1..9, 0, 1, 2. `tc = 1` only while `q = 9`. `wrap` is high for one cycle, only when `q` first reads 0.
- **Down count:** `q = 0`, `up = 0`, `en = 1` → `tc = 1` at once. Next values are 9, 8, 7, and `wrap` pulses once on the 0→9 step.
- **Load:**
  - `load = 1`, `din = 6`, `en = 1` → `q = 6` next cycle and `wrap = 0`.
  - `load = 1`, `din = 13` → `q = 9`.
  - `load = 1` while `q = 9`, `up = 1`, `en = 1` → `q = din`, not 0, and no `wrap`.
- **Enable and direction:** at `q = 4`, deassert `en` for 3 cycles → `q` holds at 4. Then toggle `up` every cycle with `en = 1` → `q` alternates 5, 4, 5, 4.
- **Reset mid-operation:** assert `rst` in the cycle where `q = 9` and `tc = 1` → `q = 0` and `wrap = 0` next cycle; the wrap is suppressed.
- **Power-of-two modulo:** rerun the first scenario with MODULO=16 → binary 0..15 followed by 0, with one `wrap` pulse per 16 cycles.

Source files
------------

// File: rtl/tff_pkg.sv
// Shared definitions for toggle-cell based counters: direction encoding
// and the helper that turns a desired next value into a toggle vector.
package tff_pkg;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  // Widest vector the shared helper handles; callers zero-extend and truncate.
  localparam int TFF_MAX_WIDTH = 32;

  typedef logic [TFF_MAX_WIDTH-1:0] tff_vec_t;

  // A T cell holding cur reaches nxt when toggled by cur ^ nxt.
  function automatic tff_vec_t tff_toggle_for(input tff_vec_t cur, input tff_vec_t nxt);
    return cur ^ nxt;
  endfunction

endpackage

// File: rtl/tff_cell.sv
// Single-bit T flip-flop with synchronous active-high reset to 0.
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  // Toggle on t, clear on rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      q <= q ^ t;
    end
  end

endmodule

// File: rtl/tff_updown_counter.sv
// Loadable modulo-N up/down counter built from a column of T cells.
// All count behaviour is expressed as a toggle vector fed to the cells;
// tc predicts a wrap on the next edge and wrap is its registered copy.
module tff_updown_counter
  import tff_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int MODULO = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  // Refuse to build with a count range the register cannot hold.
  if (WIDTH < 1 || WIDTH > TFF_MAX_WIDTH) begin : g_bad_width
    $error("tff_updown_counter: WIDTH must be 1..32");
  end
  if (MODULO < 2 || 64'(MODULO) > (64'(1) << WIDTH)) begin : g_bad_modulo
    $error("tff_updown_counter: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

  logic [WIDTH-1:0] din_clamped;
  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;
  logic [WIDTH-1:0] t;
  logic             run_and;
  logic             run_nor;
  logic             at_max;
  logic             at_zero;

  assign at_max  = (q == MAX_VAL);
  assign at_zero = (q == '0);

  // Out-of-range load values saturate to the top of the count range.
  always_comb begin
    din_clamped = din;
    if ({1'b0, din} >= MOD_EXT) begin
      din_clamped = MAX_VAL;
    end
  end

  // Binary increment/decrement toggles: a bit flips when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    up_t    = '0;
    dn_t    = '0;
    run_and = 1'b1;
    run_nor = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      up_t[i] = run_and;
      dn_t[i] = run_nor;
      run_and = run_and & q[i];
      run_nor = run_nor & ~q[i];
    end
  end

  // Toggle-vector mux: load beats count; the wrap branches jump to 0 or MODULO-1.
  always_comb begin
    t = '0;
    if (load) begin
      t = WIDTH'(tff_toggle_for(TFF_MAX_WIDTH'(q), TFF_MAX_WIDTH'(din_clamped)));
    end else if (en) begin
      if (up == DIR_UP) begin
        t = at_max ? q : up_t;
      end else begin
        t = at_zero ? MAX_VAL : dn_t;
      end
    end
  end

  // Terminal count: the next edge will wrap.
  always_comb begin
    tc = 1'b0;
    if (en && !load) begin
      tc = ((up == DIR_UP) && at_max) || ((up == DIR_DOWN) && at_zero);
    end
  end

  // One T cell per count bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .t   (t[i]),
      .q   (q[i])
    );
  end

  // Wrap pulse is the registered terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= tc;
    end
  end

endmodule

// File: tb/tb_tff_updown_counter.sv
// Bench for tff_updown_counter: a MODULO=10 and a MODULO=16 instance share
// the same inputs. Directed vector table, a power-of-two sequence, then
// random traffic compared against an arithmetic reference model.
module tb_tff_updown_counter;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] din;
  logic [3:0] q10;
  logic       tc10;
  logic       wrap10;
  logic [3:0] q16;
  logic       tc16;
  logic       wrap16;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rst;
    logic       load;
    logic       en;
    logic       up;
    logic [3:0] din;
    logic [3:0] q;
    logic       wrap;
    logic       chk_tc;
    logic       tc;
  } vec_t;

  vec_t vecs[$];

  tff_updown_counter #(.WIDTH(4), .MODULO(10)) dut10 (
    .clk (clk), .rst (rst), .en (en), .up (up), .load (load),
    .din (din), .q (q10), .tc (tc10), .wrap (wrap10)
  );

  tff_updown_counter #(.WIDTH(4), .MODULO(16)) dut16 (
    .clk (clk), .rst (rst), .en (en), .up (up), .load (load),
    .din (din), .q (q16), .tc (tc16), .wrap (wrap16)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference next count from the counter's rules in plain arithmetic.
  function automatic int model_next(int cur, int m, logic r, logic l, logic e, logic u, int d);
    if (r) return 0;
    if (l) return (d < m) ? d : m - 1;
    if (e) return u ? (cur + 1) % m : (cur + m - 1) % m;
    return cur;
  endfunction

  function automatic logic model_tc(int cur, int m, logic l, logic e, logic u);
    return e && !l && ((u && cur == m - 1) || (!u && cur == 0));
  endfunction

  task automatic applyStimulus(input logic r, input logic l, input logic e,
                               input logic u, input logic [3:0] d);
    rst  = r;
    load = l;
    en   = e;
    up   = u;
    din  = d;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
    end
  endtask

  task automatic addVec(input logic r, input logic l, input logic e, input logic u,
                        input logic [3:0] d, input logic [3:0] eq, input logic ew,
                        input logic ct, input logic et);
    vec_t v;
    v.rst = r; v.load = l; v.en = e; v.up = u; v.din = d;
    v.q = eq; v.wrap = ew; v.chk_tc = ct; v.tc = et;
    vecs.push_back(v);
  endtask

  initial begin
    int m10;
    int m16;
    logic et10;
    logic et16;
    logic r;
    logic l;
    logic e;
    logic u;
    logic [3:0] d;

    applyStimulus(H, L, H, H, 4'd0);

    // Reset held two cycles with en/up high.
    addVec(H, L, H, H, 4'd0, 4'd0, L, L, L);
    addVec(H, L, H, H, 4'd0, 4'd0, L, H, L);
    // Twelve enabled up-counts: 1..9, 0, 1, 2 with one wrap.
    for (int k = 0; k < 12; k++) begin
      addVec(L, L, H, H, 4'd0, 4'((k + 1) % 10), (k == 9), H, (k == 9));
    end
    // Load 0, then count down through the 0 -> 9 wrap.
    addVec(L, H, L, H, 4'd0, 4'd0, L, H, L);
    addVec(L, L, H, L, 4'd0, 4'd9, H, H, H);
    addVec(L, L, H, L, 4'd0, 4'd8, L, H, L);
    addVec(L, L, H, L, 4'd0, 4'd7, L, H, L);
    // Loads: plain, clamped, and load beating a pending wrap.
    addVec(L, H, H, L, 4'd6,  4'd6, L, H, L);
    addVec(L, H, L, L, 4'd13, 4'd9, L, H, L);
    addVec(L, H, H, H, 4'd3,  4'd3, L, H, L);
    // Hold at 4 with en low, then alternate direction.
    addVec(L, H, L, H, 4'd4, 4'd4, L, H, L);
    addVec(L, L, L, H, 4'd0, 4'd4, L, H, L);
    addVec(L, L, L, L, 4'd0, 4'd4, L, H, L);
    addVec(L, L, L, H, 4'd0, 4'd4, L, H, L);
    addVec(L, L, H, H, 4'd0, 4'd5, L, H, L);
    addVec(L, L, H, L, 4'd0, 4'd4, L, H, L);
    addVec(L, L, H, H, 4'd0, 4'd5, L, H, L);
    addVec(L, L, H, L, 4'd0, 4'd4, L, H, L);
    // Reset while tc is high suppresses the wrap; counting then resumes.
    addVec(L, H, L, H, 4'd9, 4'd9, L, H, L);
    addVec(H, L, H, H, 4'd0, 4'd0, L, H, H);
    addVec(L, L, H, H, 4'd0, 4'd1, L, H, L);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].din);
      if (vecs[i].chk_tc) checkOutput($sformatf("vec%0d_tc", i), 8'(tc10), 8'(vecs[i].tc));
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_q", i), 8'(q10), 8'(vecs[i].q));
      checkOutput($sformatf("vec%0d_wrap", i), 8'(wrap10), 8'(vecs[i].wrap));
    end

    // Power-of-two modulo: plain binary count with a wrap every 16 steps.
    for (int k = 0; k < 2; k++) begin
      applyStimulus(H, L, H, H, 4'd0);
      @(posedge clk);
      #1;
    end
    checkOutput("p2_reset_q", 8'(q16), 8'd0);
    checkOutput("p2_reset_wrap", 8'(wrap16), 8'd0);
    for (int k = 0; k < 17; k++) begin
      applyStimulus(L, L, H, H, 4'd0);
      checkOutput($sformatf("p2_tc%0d", k), 8'(tc16), 8'(k == 15));
      @(posedge clk);
      #1;
      checkOutput($sformatf("p2_q%0d", k), 8'(q16), 8'((k + 1) % 16));
      checkOutput($sformatf("p2_wrap%0d", k), 8'(wrap16), 8'(k == 15));
    end
    applyStimulus(L, H, L, H, 4'd0);
    @(posedge clk);
    #1;
    applyStimulus(L, L, H, L, 4'd0);
    checkOutput("p2_down_tc", 8'(tc16), 8'd1);
    @(posedge clk);
    #1;
    checkOutput("p2_down_q", 8'(q16), 8'd15);
    checkOutput("p2_down_wrap", 8'(wrap16), 8'd1);

    // Random traffic against the reference model for both moduli.
    applyStimulus(H, L, L, H, 4'd0);
    @(posedge clk);
    #1;
    m10 = 0;
    m16 = 0;
    for (int k = 0; k < 400; k++) begin
      r = ($urandom_range(0, 31) == 0);
      l = ($urandom_range(0, 7) == 0);
      e = ($urandom_range(0, 3) != 0);
      u = 1'($urandom_range(0, 1));
      d = 4'($urandom_range(0, 15));
      applyStimulus(r, l, e, u, d);
      et10 = model_tc(m10, 10, l, e, u);
      et16 = model_tc(m16, 16, l, e, u);
      checkOutput("rnd_tc10", 8'(tc10), 8'(et10));
      checkOutput("rnd_tc16", 8'(tc16), 8'(et16));
      m10 = model_next(m10, 10, r, l, e, u, int'(d));
      m16 = model_next(m16, 16, r, l, e, u, int'(d));
      @(posedge clk);
      #1;
      checkOutput("rnd_q10", 8'(q10), 8'(m10));
      checkOutput("rnd_wrap10", 8'(wrap10), 8'(et10 && !r));
      checkOutput("rnd_q16", 8'(q16), 8'(m16));
      checkOutput("rnd_wrap16", 8'(wrap16), 8'(et16 && !r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
